// File: rtl/ctu_ls_pkg.sv
// ctu_ls_pkg: shared FSM state and scan-mode encodings
// for the ctu_ls_scan load/store scan controller.
package ctu_ls_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_SRCH = 2'b00;
  localparam logic [1:0] MODE_FILL = 2'b01;
  localparam logic [1:0] MODE_CNT  = 2'b10;

endpackage

// File: rtl/ctu_ls_cmp.sv
// ctu_ls_cmp: one-stage compare of SRAM read data against the key.
// Ports: strobe/adr register the read issued this cycle; next cycle
// hit flags a match on rdata and hit_adr gives its address.
// Macro CTU_LS_MASK_EN adds the mask input to the compare.
module ctu_ls_cmp #(
  parameter int A = 8,
  parameter int D = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         strobe,
  input  logic [A-1:0] adr,
  input  logic [D-1:0] key,
`ifdef CTU_LS_MASK_EN
  input  logic [D-1:0] mask,
`endif
  input  logic [D-1:0] rdata,
  output logic         hit,
  output logic [A-1:0] hit_adr
);

  logic         vld;
  logic [A-1:0] adr_q;
  logic [D-1:0] diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      adr_q <= '0;
    end else begin
      vld   <= strobe;
      adr_q <= adr;
    end
  end

`ifdef CTU_LS_MASK_EN
  assign diff = (rdata ^ key) & mask;
`else
  assign diff = rdata ^ key;
`endif

  assign hit     = vld && (diff == '0);
  assign hit_adr = adr_q;

endmodule

// File: rtl/ctu_ls_scan.sv
// ctu_ls_scan: sweeps an ordered address range over a single-port
// SRAM to search, fill or count matches.
// Ports: start/abort/mode/sch_adr1/sch_adr2/sch_key control a scan;
// mem_* drive the SRAM (1-cycle read latency on mem_rdata);
// busy/done/found/match_adr/match_cnt report status and results.
// Macro CTU_LS_MASK_EN adds input sch_mask for masked compares.
module ctu_ls_scan
  import ctu_ls_pkg::*;
#(
  parameter int A  = 8,
  parameter int D  = 8,
  parameter int CW = A + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [A-1:0]  sch_adr1,
  input  logic [A-1:0]  sch_adr2,
  input  logic [D-1:0]  sch_key,
`ifdef CTU_LS_MASK_EN
  input  logic [D-1:0]  sch_mask,
`endif
  input  logic [D-1:0]  mem_rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [A-1:0]  mem_adr,
  output logic [D-1:0]  mem_wdata,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic [A-1:0]  match_adr,
  output logic [CW-1:0] match_cnt
);

  localparam logic [A-1:0]  ONE_A = 1;
  localparam logic [CW-1:0] ONE_C = 1;

  state_t       state, nxt;
  logic [1:0]   mode_q;
  logic [A-1:0] a1_q, a2_q;
  logic [A-1:0] lo, hi, ptr;
  logic [D-1:0] key_q;
  logic         same;
`ifdef CTU_LS_MASK_EN
  logic [D-1:0] mask_q;
`endif

  logic         fill, srch, last, live;
  logic         kill, rd, strobe;
  logic         hit, take, early;
  logic [A-1:0] hit_adr;

  assign fill = (mode_q == MODE_FILL);
  assign srch = (mode_q == MODE_SRCH);
  assign last = same || (ptr == hi);
  assign live = state inside {SETUP, RUN, DRAIN};
  assign kill = live && abort;
  assign rd   = (state == RUN) && !fill;
  // a read whose result will never be looked at is not tracked
  assign strobe = rd && (nxt != DONE);
  assign take   = hit && !kill;
  assign early  = srch && take && !found;

  ctu_ls_cmp #(.A(A), .D(D)) u_cmp (
    .clk     (clk),
    .rst_n   (rst_n),
    .strobe  (strobe),
    .adr     (ptr),
    .key     (key_q),
`ifdef CTU_LS_MASK_EN
    .mask    (mask_q),
`endif
    .rdata   (mem_rdata),
    .hit     (hit),
    .hit_adr (hit_adr)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (start) nxt = SETUP;
      SETUP: nxt = RUN;
      RUN: begin
        if (early)     nxt = DONE;
        else if (last) nxt = fill ? DONE : DRAIN;
      end
      DRAIN: nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
    if (kill) nxt = DONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= '0;
      a1_q      <= '0;
      a2_q      <= '0;
      lo        <= '0;
      hi        <= '0;
      ptr       <= '0;
      key_q     <= '0;
      same      <= 1'b0;
`ifdef CTU_LS_MASK_EN
      mask_q    <= '0;
`endif
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      match_adr <= '0;
      match_cnt <= '0;
    end else begin
      state     <= nxt;
      mem_ce    <= (nxt == RUN);
      mem_we    <= (nxt == RUN) && fill;
      mem_wdata <= ((nxt == RUN) && fill) ? key_q : '0;
      busy      <= nxt inside {SETUP, RUN, DRAIN};
      done      <= (nxt == DONE);

      if ((state == IDLE) && start) begin
        mode_q    <= (mode == 2'b11) ? MODE_CNT : mode;
        a1_q      <= sch_adr1;
        a2_q      <= sch_adr2;
        key_q     <= sch_key;
`ifdef CTU_LS_MASK_EN
        mask_q    <= sch_mask;
`endif
        found     <= 1'b0;
        match_adr <= '0;
        match_cnt <= '0;
      end

      if (state == SETUP) begin
        lo   <= (a1_q < a2_q) ? a1_q : a2_q;
        hi   <= (a1_q < a2_q) ? a2_q : a1_q;
        ptr  <= (a1_q < a2_q) ? a1_q : a2_q;
        same <= (a1_q == a2_q);
      end

      // leaving RUN on the last address means ptr never wraps
      if ((state == RUN) && (nxt == RUN))
        ptr <= ptr + ONE_A;

      if (take) begin
        if (match_cnt != '1)
          match_cnt <= match_cnt + ONE_C;
        if (!found) begin
          found     <= 1'b1;
          match_adr <= hit_adr;
        end
      end
    end
  end

  assign mem_adr = ptr;

endmodule

// File: tb/tb_ctu_ls_scan.sv
// tb_ctu_ls_scan: scoreboard bench for ctu_ls_scan with an SRAM
// model; expected strobes are queued at launch and popped at the end.
module tb_ctu_ls_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, abort;
  logic [1:0] mode;
  logic [7:0] sch_adr1, sch_adr2, sch_key;
`ifdef CTU_LS_MASK_EN
  logic [7:0] sch_mask;
`endif
  logic [7:0] mem_rdata;
  logic       mem_ce, mem_we;
  logic [7:0] mem_adr, mem_wdata;
  logic       busy, done, found;
  logic [7:0] match_adr;
  logic [8:0] match_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic [16:0] act_log [$];
  logic [16:0] exp_q [$];

  always #5 clk = ~clk;

  ctu_ls_scan #(.A(8), .D(8), .CW(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .sch_adr1  (sch_adr1),
    .sch_adr2  (sch_adr2),
    .sch_key   (sch_key),
`ifdef CTU_LS_MASK_EN
    .sch_mask  (sch_mask),
`endif
    .mem_rdata (mem_rdata),
    .mem_ce    (mem_ce),
    .mem_we    (mem_we),
    .mem_adr   (mem_adr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .found     (found),
    .match_adr (match_adr),
    .match_cnt (match_cnt)
  );

  always @(posedge clk)
    if (mem_ce && !mem_we) mem_rdata <= mem[mem_adr];

  always @(negedge clk)
    if (mem_ce) act_log.push_back({mem_we, mem_adr, mem_wdata});

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic push_rng(input logic we, input logic [7:0] a,
                          input int n, input logic [7:0] d);
    logic [7:0] ad;
    for (int i = 0; i < n; i++) begin
      ad = a + 8'(i);
      exp_q.push_back({we, ad, d});
    end
  endtask

  task automatic run_scan(input logic [1:0] m,
                          input logic [7:0] a1, a2, k,
                          output int lat, output int bn);
    @(negedge clk);
    mode = m; sch_adr1 = a1; sch_adr2 = a2;
    sch_key = k; start = 1'b1;
    lat = 0; bn = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bn++;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({mem_ce, mem_we, busy, done, found} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {mem_ce, mem_we, busy, done, found});
    end
    checks++;
    if ({mem_adr, mem_wdata, match_adr, match_cnt} !== 33'b0) begin
      errors++;
      $display("FAIL reset_buses got %h want 0",
               {mem_adr, mem_wdata, match_adr, match_cnt});
    end
  endtask

  task automatic test_fill();
    int lat, bn, base, n;
    logic [16:0] e, a;
    fill_mem(8'h00);
    base = act_log.size();
    push_rng(1'b1, 8'h10, 4, 8'hA5);
    run_scan(2'b01, 8'h10, 8'h13, 8'hA5, lat, bn);
    checks++;
    if (lat !== 6) begin
      errors++; $display("FAIL fill_lat got %0d want 6", lat);
    end
    n = act_log.size() - base;
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL fill_nstb got %0d want 4", n);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (i < n) ? act_log[base + i] : 'x;
      checks++;
      if (a !== e) begin
        errors++; $display("FAIL fill_stb got %h want %h", a, e);
      end
    end
    checks++;
    if ({found, match_cnt} !== 10'b0) begin
      errors++;
      $display("FAIL fill_res got %b/%h want 0/0", found, match_cnt);
    end
  endtask

  task automatic test_search_rev();
    int lat, bn, base, n;
    logic [16:0] e, a;
    fill_mem(8'h00);
    mem[8'h1B] = 8'h3C;
    mem[8'h1C] = 8'h3C;
    base = act_log.size();
    push_rng(1'b0, 8'h18, 5, 8'h00);
    run_scan(2'b00, 8'h20, 8'h18, 8'h3C, lat, bn);
    checks++;
    if (!done) begin
      errors++; $display("FAIL srch_timeout got 0 want 1");
    end
    n = act_log.size() - base;
    checks++;
    if (n < 4 || n > 5) begin
      errors++; $display("FAIL srch_nstb got %0d want 4..5", n);
    end
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = act_log[base + i];
      checks++;
      if (a[16:8] !== e[16:8]) begin
        errors++;
        $display("FAIL srch_stb got %h want %h", a[16:8], e[16:8]);
      end
    end
    exp_q.delete();
    checks++;
    if ({found, match_adr, match_cnt} !== {1'b1, 8'h1B, 9'd1}) begin
      errors++;
      $display("FAIL srch_res got %b/%h/%h want 1/1b/001",
               found, match_adr, match_cnt);
    end
  endtask

  task automatic test_count_single();
    int lat, bn, base, n;
    logic [16:0] e, a;
    fill_mem(8'h00);
    mem[8'hFF] = 8'h77;
    mem[8'h00] = 8'h77;
    base = act_log.size();
    push_rng(1'b0, 8'hFF, 1, 8'h00);
    run_scan(2'b11, 8'hFF, 8'hFF, 8'h77, lat, bn);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL cnt1_lat got %0d want 4", lat);
    end
    n = act_log.size() - base;
    checks++;
    if (n !== 1) begin
      errors++; $display("FAIL cnt1_nstb got %0d want 1", n);
    end
    e = exp_q.pop_front();
    a = (n > 0) ? act_log[base] : 'x;
    checks++;
    if (a[16:8] !== e[16:8]) begin
      errors++;
      $display("FAIL cnt1_stb got %h want %h", a[16:8], e[16:8]);
    end
    checks++;
    if ({found, match_adr, match_cnt} !== {1'b1, 8'hFF, 9'd1}) begin
      errors++;
      $display("FAIL cnt1_res got %b/%h/%h want 1/ff/001",
               found, match_adr, match_cnt);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("FAIL cnt1_pulse got %b want 0", done);
    end
  endtask

  task automatic test_count_full();
    int lat, bn, base, n;
    logic [16:0] e, a;
    fill_mem(8'h5A);
    base = act_log.size();
    push_rng(1'b0, 8'h00, 256, 8'h00);
    run_scan(2'b10, 8'h00, 8'hFF, 8'h5A, lat, bn);
    checks++;
    if (lat !== 259) begin
      errors++; $display("FAIL cntf_lat got %0d want 259", lat);
    end
    checks++;
    if (bn !== 258) begin
      errors++; $display("FAIL cntf_busy got %0d want 258", bn);
    end
    n = act_log.size() - base;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (i < n) ? act_log[base + i] : 'x;
      checks++;
      if (a[16:8] !== e[16:8]) begin
        errors++;
        $display("FAIL cntf_stb got %h want %h", a[16:8], e[16:8]);
      end
    end
    checks++;
    if ({found, match_adr, match_cnt} !== {1'b1, 8'h00, 9'h100}) begin
      errors++;
      $display("FAIL cntf_res got %b/%h/%h want 1/00/100",
               found, match_adr, match_cnt);
    end
  endtask

  task automatic test_abort();
    int lat, base, n;
    logic [16:0] e, a;
    fill_mem(8'h00);
    base = act_log.size();
    push_rng(1'b1, 8'h40, 3, 8'hC3);
    @(negedge clk);
    mode = 2'b01; sch_adr1 = 8'h40; sch_adr2 = 8'h4F;
    sch_key = 8'hC3; start = 1'b1;
    lat = 0;
    while (lat < 4) begin
      @(negedge clk);
      start = 1'b0;
      lat++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if ({done, mem_ce, mem_we} !== 3'b100) begin
      errors++;
      $display("FAIL abrt_done got %b want 100",
               {done, mem_ce, mem_we});
    end
    mode = 2'b01; sch_adr1 = 8'h60; sch_adr2 = 8'h61;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({busy, done} !== 2'b00) begin
      errors++; $display("FAIL abrt_ign got %b want 00", {busy, done});
    end
    repeat (3) @(negedge clk);
    n = act_log.size() - base;
    checks++;
    if (n !== 3) begin
      errors++; $display("FAIL abrt_nstb got %0d want 3", n);
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      a = (i < n) ? act_log[base + i] : 'x;
      checks++;
      if (a !== e) begin
        errors++; $display("FAIL abrt_stb got %h want %h", a, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bn;
    @(negedge clk);
    mode = 2'b01; sch_adr1 = 8'h80; sch_adr2 = 8'h8F;
    sch_key = 8'h11; start = 1'b1;
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (mem_ce !== 1'b1) begin
      errors++; $display("FAIL rmid_pre got %b want 1", mem_ce);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_ce, mem_we, busy, done} !== 4'b0) begin
      errors++;
      $display("FAIL rmid_ce got %b want 0000",
               {mem_ce, mem_we, busy, done});
    end
    checks++;
    if ({mem_adr, mem_wdata, found, match_adr, match_cnt} !== 34'b0)
    begin
      errors++;
      $display("FAIL rmid_out got %h want 0",
               {mem_adr, mem_wdata, found, match_adr, match_cnt});
    end
    @(negedge clk);
    rst_n = 1'b1;
    fill_mem(8'h00);
    mem[8'h32] = 8'h9E;
    run_scan(2'b00, 8'h30, 8'h33, 8'h9E, lat, bn);
    checks++;
    if ({found, match_adr, match_cnt} !== {1'b1, 8'h32, 9'd1}) begin
      errors++;
      $display("FAIL rmid_run got %b/%h/%h want 1/32/001",
               found, match_adr, match_cnt);
    end
  endtask

`ifdef CTU_LS_MASK_EN
  task automatic test_mask();
    int lat, bn;
    fill_mem(8'h00);
    mem[8'h05] = 8'h5A;
    sch_mask = 8'hF0;
    run_scan(2'b00, 8'h05, 8'h05, 8'h50, lat, bn);
    sch_mask = 8'hFF;
    checks++;
    if ({found, match_adr} !== {1'b1, 8'h05}) begin
      errors++;
      $display("FAIL mask_hit got %b/%h want 1/05", found, match_adr);
    end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    mode = 2'b00; sch_adr1 = '0; sch_adr2 = '0; sch_key = '0;
`ifdef CTU_LS_MASK_EN
    sch_mask = 8'hFF;
`endif
    fill_mem(8'h00);
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_fill();
    test_search_rev();
    test_count_single();
    test_count_full();
    test_abort();
    test_reset_mid();
`ifdef CTU_LS_MASK_EN
    test_mask();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
